// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer: saves EPC/Cause, fetches the vector byte for the
// winning cause, loads it into PC and hands the datapath back to the control unit.
module exc_sequencer #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [31:0] VEC_OPCODE  = 32'd253,
    parameter logic [31:0] VEC_OVF     = 32'd254,
    parameter logic [31:0] VEC_DIV0    = 32'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_opcode,
    input  logic        req_ovf,
    input  logic        req_div0,
    input  logic [31:0] pc,
    input  logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        cause_write,
    output logic [31:0] cause_data,
    output logic        mem_addr_sel,
    output logic [31:0] mem_addr,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SAVE = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        C_OPCODE = 2'd0,
        C_OVF    = 2'd1,
        C_DIV0   = 2'd2
    } cause_e;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cause_e        cause_q, cause_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   vector;

    // Only the top byte of the fetched word is the vector target.
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_data[23:0];

    always_comb begin
        case (cause_q)
            C_OPCODE: vector = VEC_OPCODE;
            C_OVF:    vector = VEC_OVF;
            C_DIV0:   vector = VEC_DIV0;
            default:  vector = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, independent of statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= C_OPCODE;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d      = S_IDLE;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        busy         = 1'b0;
        done         = 1'b0;
        epc_write    = 1'b0;
        epc_data     = 32'd0;
        cause_write  = 1'b0;
        cause_data   = 32'd0;
        mem_addr_sel = 1'b0;
        mem_addr     = 32'd0;
        pc_write     = 1'b0;
        pc_data      = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_opcode || req_ovf || req_div0) begin
                    pc_d    = pc;
                    state_d = S_SAVE;
                    if (req_opcode)   cause_d = C_OPCODE;
                    else if (req_ovf) cause_d = C_OVF;
                    else              cause_d = C_DIV0;
                end
            end
            S_SAVE: begin
                busy        = 1'b1;
                epc_write   = 1'b1;
                epc_data    = pc_q - 32'd4;
                cause_write = 1'b1;
                cause_data  = {30'd0, cause_q};
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                busy         = 1'b1;
                mem_addr_sel = 1'b1;
                mem_addr     = vector;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                mem_addr_sel = 1'b1;
                mem_addr     = vector;
                pc_write     = 1'b1;
                pc_data      = {24'd0, mem_data[31:24]};
                state_d      = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                cause_d = C_OPCODE;
                pc_d    = 32'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Table-driven bench for exc_sequencer: per-cycle input/expected-output rows fed
// through a scoreboard queue, plus hand-written reset and MEM_LATENCY=4 sequences.
module tb_exc_sequencer;

    typedef struct packed {
        logic [2:0]  state;
        logic        busy;
        logic        done;
        logic        epc_write;
        logic [31:0] epc_data;
        logic        cause_write;
        logic [31:0] cause_data;
        logic        mem_addr_sel;
        logic [31:0] mem_addr;
        logic        pc_write;
        logic [31:0] pc_data;
    } out_t;

    typedef struct {
        logic        rst;
        logic [2:0]  req;   // {opcode, ovf, div0}
        logic [31:0] pc;
        logic [31:0] md;
        out_t        exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_opcode, req_ovf, req_div0;
    logic [31:0] pc, mem_data;
    logic        busy, done, epc_write, cause_write, mem_addr_sel, pc_write;
    logic [31:0] epc_data, cause_data, mem_addr, pc_data;
    logic [2:0]  state;

    logic        req_opcode4, req_ovf4, req_div04;
    logic [31:0] pc4, mem_data4;
    logic        busy4, done4, epc_write4, cause_write4, mem_addr_sel4, pc_write4;
    logic [31:0] epc_data4, cause_data4, mem_addr4, pc_data4;
    logic [2:0]  state4;

    out_t act2, act4;
    int   checks   = 0;
    int   failures = 0;
    out_t sb[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    exc_sequencer dut (
        .clock(clock), .reset(reset),
        .req_opcode(req_opcode), .req_ovf(req_ovf), .req_div0(req_div0),
        .pc(pc), .mem_data(mem_data),
        .busy(busy), .done(done),
        .epc_write(epc_write), .epc_data(epc_data),
        .cause_write(cause_write), .cause_data(cause_data),
        .mem_addr_sel(mem_addr_sel), .mem_addr(mem_addr),
        .pc_write(pc_write), .pc_data(pc_data),
        .state(state)
    );

    exc_sequencer #(.MEM_LATENCY(4)) dut4 (
        .clock(clock), .reset(reset),
        .req_opcode(req_opcode4), .req_ovf(req_ovf4), .req_div0(req_div04),
        .pc(pc4), .mem_data(mem_data4),
        .busy(busy4), .done(done4),
        .epc_write(epc_write4), .epc_data(epc_data4),
        .cause_write(cause_write4), .cause_data(cause_data4),
        .mem_addr_sel(mem_addr_sel4), .mem_addr(mem_addr4),
        .pc_write(pc_write4), .pc_data(pc_data4),
        .state(state4)
    );

    assign act2 = {state, busy, done, epc_write, epc_data, cause_write, cause_data,
                   mem_addr_sel, mem_addr, pc_write, pc_data};
    assign act4 = {state4, busy4, done4, epc_write4, epc_data4, cause_write4, cause_data4,
                   mem_addr_sel4, mem_addr4, pc_write4, pc_data4};

    function automatic out_t e_idle();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t e_save(input logic [31:0] epc, input logic [31:0] c);
        out_t o = '0;
        o.state = 3'd1; o.busy = 1'b1;
        o.epc_write = 1'b1; o.epc_data = epc;
        o.cause_write = 1'b1; o.cause_data = c;
        return o;
    endfunction

    function automatic out_t e_wait(input logic [31:0] vec);
        out_t o = '0;
        o.state = 3'd2; o.busy = 1'b1;
        o.mem_addr_sel = 1'b1; o.mem_addr = vec;
        return o;
    endfunction

    function automatic out_t e_load(input logic [31:0] vec, input logic [31:0] pcd);
        out_t o = '0;
        o.state = 3'd3; o.busy = 1'b1;
        o.mem_addr_sel = 1'b1; o.mem_addr = vec;
        o.pc_write = 1'b1; o.pc_data = pcd;
        return o;
    endfunction

    function automatic out_t e_done();
        out_t o = '0;
        o.state = 3'd4; o.busy = 1'b1; o.done = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got st=%0d busy=%b done=%b ew=%b ed=%h cw=%b cd=%h sel=%b ma=%h pw=%b pd=%h | want st=%0d busy=%b done=%b ew=%b ed=%h cw=%b cd=%h sel=%b ma=%h pw=%b pd=%h",
                     name, a.state, a.busy, a.done, a.epc_write, a.epc_data, a.cause_write,
                     a.cause_data, a.mem_addr_sel, a.mem_addr, a.pc_write, a.pc_data,
                     e.state, e.busy, e.done, e.epc_write, e.epc_data, e.cause_write,
                     e.cause_data, e.mem_addr_sel, e.mem_addr, e.pc_write, e.pc_data);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, push the expectation,
    // then pop and compare once the combinational outputs have settled.
    task automatic step(input bit sel4, input logic rst_v, input logic [2:0] req,
                        input logic [31:0] pc_v, input logic [31:0] md_v,
                        input out_t e, input string name);
        @(negedge clock);
        reset = rst_v;
        {req_opcode,  req_ovf,  req_div0}  = sel4 ? 3'b000 : req;
        {req_opcode4, req_ovf4, req_div04} = sel4 ? req : 3'b000;
        pc        = sel4 ? 32'd0 : pc_v;
        mem_data  = sel4 ? 32'd0 : md_v;
        pc4       = sel4 ? pc_v : 32'd0;
        mem_data4 = sel4 ? md_v : 32'd0;
        sb.push_back(e);
        #1;
        check(name, sel4 ? act4 : act2, sb.pop_front());
    endtask

    task automatic add(input logic rst, input logic [2:0] req, input logic [31:0] p,
                       input logic [31:0] md, input out_t e);
        vec_t v;
        v.rst = rst; v.req = req; v.pc = p; v.md = md; v.exp = e;
        tbl.push_back(v);
    endtask

    // Request cycle, SAVE, two WAITs, LOAD, DONE; pc is scrambled after acceptance.
    task automatic add_seq(input logic [2:0] req, input logic [31:0] p, input logic [31:0] epc,
                           input logic [31:0] c, input logic [31:0] vec,
                           input logic [31:0] md, input logic [31:0] pcd);
        add(1'b1, req,    p,            32'd0,        e_idle());
        add(1'b1, 3'b000, 32'hDEADBEEF, 32'd0,        e_save(epc, c));
        add(1'b1, 3'b000, 32'h12345678, 32'hFF000000, e_wait(vec));
        add(1'b1, 3'b000, 32'd0,        32'hEE000000, e_wait(vec));
        add(1'b1, 3'b000, 32'd0,        md,           e_load(vec, pcd));
        add(1'b1, 3'b000, 32'd0,        32'd0,        e_done());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {req_opcode, req_ovf, req_div0} = 3'b000;
        {req_opcode4, req_ovf4, req_div04} = 3'b000;
        pc = 32'd0; mem_data = 32'd0; pc4 = 32'd0; mem_data4 = 32'd0;

        add(1'b0, 3'b000, 32'd0, 32'd0, e_idle());
        add(1'b0, 3'b010, 32'h40, 32'd0, e_idle());
        // Overflow
        add_seq(3'b010, 32'h40, 32'h3C, 32'd1, 32'd254, 32'h7A000000, 32'h7A);
        add(1'b1, 3'b000, 32'd0, 32'd0, e_idle());
        // Priority: all three requests at once
        add_seq(3'b111, 32'h100, 32'hFC, 32'd0, 32'd253, 32'hAB123456, 32'hAB);
        add(1'b1, 3'b000, 32'd0, 32'd0, e_idle());
        // div0 pulsed during WAIT is ignored and not queued
        add(1'b1, 3'b100, 32'h200, 32'd0, e_idle());
        add(1'b1, 3'b000, 32'd0,   32'd0, e_save(32'h1FC, 32'd0));
        add(1'b1, 3'b001, 32'd0,   32'd0, e_wait(32'd253));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_wait(32'd253));
        add(1'b1, 3'b000, 32'd0,   32'h55000000, e_load(32'd253, 32'h55));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_done());
        add(1'b1, 3'b000, 32'd0,   32'd0, e_idle());
        add(1'b1, 3'b000, 32'd0,   32'd0, e_idle());
        // div0 raised in DONE and held into IDLE starts a new sequence
        add(1'b1, 3'b100, 32'h300, 32'd0, e_idle());
        add(1'b1, 3'b000, 32'd0,   32'd0, e_save(32'h2FC, 32'd0));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_wait(32'd253));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_wait(32'd253));
        add(1'b1, 3'b000, 32'd0,   32'h01FFFFFF, e_load(32'd253, 32'h01));
        add(1'b1, 3'b001, 32'h400, 32'd0, e_done());
        add(1'b1, 3'b001, 32'h400, 32'd0, e_idle());
        add(1'b1, 3'b001, 32'h404, 32'd0, e_save(32'h3FC, 32'd2));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_wait(32'd255));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_wait(32'd255));
        add(1'b1, 3'b000, 32'd0,   32'hFE000000, e_load(32'd255, 32'hFE));
        add(1'b1, 3'b000, 32'd0,   32'd0, e_done());
        add(1'b1, 3'b000, 32'd0,   32'd0, e_idle());
        // EPC wrap-around at pc=0
        add_seq(3'b100, 32'd0, 32'hFFFFFFFC, 32'd0, 32'd253, 32'h80000000, 32'h80);
        add(1'b1, 3'b000, 32'd0, 32'd0, e_idle());

        foreach (tbl[i])
            step(1'b0, tbl[i].rst, tbl[i].req, tbl[i].pc, tbl[i].md, tbl[i].exp,
                 $sformatf("vec%0d", i));

        // Reset asserted in the first WAIT cycle aborts the sequence
        step(1'b0, 1'b1, 3'b100, 32'h500, 32'd0, e_idle(), "rst_req");
        step(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, e_save(32'h4FC, 32'd0), "rst_save");
        step(1'b0, 1'b0, 3'b000, 32'd0, 32'hAA000000, e_wait(32'd253), "rst_wait");
        step(1'b0, 1'b0, 3'b000, 32'd0, 32'hAA000000, e_idle(), "rst_idle0");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 3'b000, 32'd0, 32'hAA000000, e_idle(), $sformatf("rst_after%0d", i));

        // MEM_LATENCY=4 instance: pc_write at N+6, vector held for 5 cycles
        step(1'b1, 1'b1, 3'b100, 32'h1000, 32'd0, e_idle(), "l4_req");
        step(1'b1, 1'b1, 3'b000, 32'h2222, 32'd0, e_save(32'hFFC, 32'd0), "l4_save");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 3'b000, 32'd0, 32'h11000000 * (i + 1), e_wait(32'd253),
                 $sformatf("l4_wait%0d", i));
        step(1'b1, 1'b1, 3'b000, 32'd0, 32'hC3000000, e_load(32'd253, 32'hC3), "l4_load");
        step(1'b1, 1'b1, 3'b000, 32'd0, 32'd0, e_done(), "l4_done");
        step(1'b1, 1'b1, 3'b000, 32'd0, 32'd0, e_idle(), "l4_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Multicycle exception sequencer that takes over the MIPS datapath when the main control unit flags an invalid opcode, an ALU overflow or a divide-by-zero.
- Writes EPC and Cause, then drives the memory address with the cause's vector location and waits out the memory read latency.
- Loads PC from the vector byte, then hands control back to the main control unit.
- Sits beside the control unit; the top level muxes its outputs onto EPC, Cause, memory address and PC when it is busy.

Parameters:
MEM_LATENCY, 2, cycles the memory address must be held before mem_data is valid (legal range ≥1)
VEC_OPCODE, 32'd253, vector byte address for invalid opcode
VEC_OVF, 32'd254, vector byte address for overflow
VEC_DIV0, 32'd255, vector byte address for divide-by-zero

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req_opcode  in  1  invalid-opcode request, level, from control unit
req_ovf  in  1  overflow request, level
req_div0  in  1  divide-by-zero request, level
pc  in  32  current PC value (already PC+4)
mem_data  in  32  memory Dataout
busy  out  1  sequencer owns datapath; control unit must stall
done  out  1  one-cycle pulse, sequence complete
epc_write  out  1  EPC load enable
epc_data  out  32  value for EPC
cause_write  out  1  Cause load enable
cause_data  out  32  value for Cause
mem_addr_sel  out  1  1 = memory address comes from mem_addr
mem_addr  out  32  vector address
pc_write  out  1  PC load enable
pc_data  out  32  new PC
state  out  3  current state, for debug/waveform

Behaviour:
- All state changes occur on the rising edge of clock; reset is sampled only on that edge.
- reset=0 forces, on the next edge:
  - state=IDLE, wait counter=0, latched cause and PC cleared.
  - All outputs 0: busy, done, epc_write, cause_write, mem_addr_sel, pc_write, epc_data, cause_data, mem_addr, pc_data.
  - This applies in any state, including mid-sequence; no partial write completes after reset.
- State encoding: IDLE=0, SAVE=1, WAIT=2, LOAD=3, DONE=4. Values 5-7 are illegal and return to IDLE on the next edge with all outputs 0.
- IDLE:
  - Outputs 0.
  - If any req is 1, latch pc and the winning cause; go to SAVE.
  - Priority: req_opcode > req_ovf > req_div0.
  - Cause codes: opcode=0, ovf=1, div0=2.
- SAVE (1 cycle):
  - busy=1, epc_write=1, cause_write=1.
  - epc_data = latched pc − 4, modulo 2^32 (pc=0 gives 32'hFFFFFFFC).
  - cause_data = zero-extended cause code.
  - Next state: WAIT, with counter=0.
- WAIT (MEM_LATENCY cycles):
  - busy=1, mem_addr_sel=1, mem_addr = vector of the latched cause.
  - Counter increments each cycle; when counter = MEM_LATENCY−1, go to LOAD.
- LOAD (1 cycle):
  - busy=1, mem_addr_sel=1, mem_addr held.
  - pc_write=1, pc_data = {24'b0, mem_data[31:24]} (big-endian: the byte at the vector address).
  - Next state: DONE.
- DONE (1 cycle):
  - busy=1, done=1, all write enables 0.
  - Next state: IDLE.
- Timing: for a request accepted in IDLE at cycle N:
  - epc_write at N+1.
  - pc_write at N+2+MEM_LATENCY.
  - done at N+3+MEM_LATENCY.
  - With the default MEM_LATENCY=2: pc_write at N+4, done at N+5.
- Requests in any state other than IDLE are ignored and not queued.
- A request still asserted when IDLE is re-entered starts a new sequence in that cycle; the control unit must drop it on done.
- epc_data, cause_data, mem_addr and pc_data are 0 whenever their enable/select is 0.
- The latched pc and cause are stable from SAVE through DONE, regardless of changes on the pc or req inputs.

Test Plan:
- Overflow: reset low 2 cycles, then high; pc=32'h00000040, pulse req_ovf at N → epc_write at N+1 with epc_data=32'h3C; cause_data=1; mem_addr=254 for N+2..N+4; mem_data=32'h7A000000 → pc_write at N+4 with pc_data=32'h7A; done at N+5; busy=0 at N+6.
- Priority: req_opcode=req_ovf=req_div0=1 in the same IDLE cycle → cause_data=0, mem_addr=253.
- Ignored request: req_div0 pulsed during WAIT of an opcode sequence → no second sequence; state=IDLE after done. Held req_div0 into IDLE → new sequence with cause_data=2, mem_addr=255.
- Wrap-around: pc=0, req_opcode → epc_data=32'hFFFFFFFC.
- Reset mid-sequence: reset=0 in the first WAIT cycle → next edge all outputs 0, state=0; pc_write never asserted.
- MEM_LATENCY=4 build: pc_write exactly at N+6; mem_addr held constant for 5 cycles (4 WAIT cycles plus LOAD); mem_data changes before N+6 do not affect pc_data.
